// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM encoding and
// bit positions inside the first (status) byte of a mouse packet.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B1   = 2'd1,
    ST_B2   = 2'd2,
    ST_B3   = 2'd3
  } state_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

endpackage

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte stream in from the PS/2 receiver, decoded mouse state out to the
// cursor/object logic.
interface ps2_mouse_packet_decoder_if #(
  parameter int POS_W = 10
);
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              pkt_valid;
  logic [2:0]        btn;
  logic signed [8:0] delta_x;
  logic signed [8:0] delta_y;
  logic signed [3:0] wheel;
  logic [8:0]        vx;
  logic [8:0]        vy;
  logic              dirx;
  logic              diry;
  logic [POS_W-1:0]  pos_x;
  logic [POS_W-1:0]  pos_y;
  logic [7:0]        err_cnt;

  modport master (
    output byte_data, byte_ready,
    input  pkt_valid, btn, delta_x, delta_y, wheel, vx, vy, dirx, diry,
           pos_x, pos_y, err_cnt
  );

  modport slave (
    input  byte_data, byte_ready,
    output pkt_valid, btn, delta_x, delta_y, wheel, vx, vy, dirx, diry,
           pos_x, pos_y, err_cnt
  );
endinterface

// File: rtl/ps2_mouse_packet_decoder_ready_edge.sv
// Samples the receiver's ready level and emits a one-cycle accept pulse on
// each rising edge, one clock after the 0->1 pattern is seen.
module ps2_ready_edge (
  input  logic clk,
  input  logic rst,
  input  logic byte_ready,
  output logic accept
);
  logic [1:0] samp_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_p0 <= 2'b00;
      accept  <= 1'b0;
    end else begin
      samp_p0 <= {samp_p0[0], byte_ready};
      accept  <= (samp_p0 == 2'b01);
    end
  end
endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles PS/2 mouse bytes into packets and derives buttons, deltas,
// velocity, clamped screen position and a sync/timeout error count.
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int PKT_BYTES   = 3,
  parameter int TIMEOUT_CYC = 9_999_999,
  parameter int VEL_SHIFT   = 1,
  parameter int POS_W       = 10,
  parameter int X_MAX       = 590,
  parameter int Y_MAX       = 430,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240
) (
  input logic                     clk,
  input logic                     rst,
  ps2_mouse_packet_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT_CYC);
  localparam logic signed [POS_W+1:0] X_MAX_S = (POS_W+2)'(X_MAX);
  localparam logic signed [POS_W+1:0] Y_MAX_S = (POS_W+2)'(Y_MAX);

  function automatic logic signed [8:0] sat_delta(input logic sgn, input logic ovf,
                                                  input logic [7:0] mag);
    if (ovf) return sgn ? 9'sh100 : 9'sh0FF;
    return $signed({sgn, mag});
  endfunction

  function automatic logic [8:0] mag9(input logic signed [8:0] s);
    logic signed [9:0] w;
    w = s;
    if (w < 0) w = -w;
    return w[8:0];
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [POS_W+1:0] n,
                                                 input logic signed [POS_W+1:0] hi);
    if (n < 0) return '0;
    if (n > hi) return hi[POS_W-1:0];
    return n[POS_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic              vld_p0, vld_p1, last, drop, abort, timeout;
  logic [CNT_W-1:0]  idle_cnt;
  logic [2:0]        btn_p1;
  logic [3:0]        flags_p1;
  logic [7:0]        b1_p1, b2_p1;
  logic [3:0]        b3_p1;
  logic signed [8:0] dx_p1, dy_p1, sx_p1, sy_p1;
  logic signed [POS_W+1:0] nx_p1, ny_p1;

  ps2_ready_edge u_edge (
    .clk        (clk),
    .rst        (rst),
    .byte_ready (bus.byte_ready),
    .accept     (vld_p0)
  );

  // An accept in the same cycle always pre-empts the timeout.
  assign timeout = !vld_p0 && (idle_cnt == TO_LAST);

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    drop    = 1'b0;
    abort   = 1'b0;
    if (vld_p0) begin
      case (state_q)
        ST_IDLE: if (bus.byte_data[SYNC]) state_d = ST_B1;
                 else drop = 1'b1;
        ST_B1:   state_d = ST_B2;
        ST_B2:   if (PKT_BYTES == 4) state_d = ST_B3;
                 else begin state_d = ST_IDLE; last = 1'b1; end
        default: begin state_d = ST_IDLE; last = 1'b1; end
      endcase
    end else if (timeout && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      abort   = 1'b1;
    end
  end

  // p0 -> p1: capture accepted bytes into their packet slots
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vld_p1   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= last;
      if (vld_p0)                  idle_cnt <= '0;
      else if (idle_cnt != TO_FULL) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      case (state_q)
        ST_IDLE: begin
          btn_p1   <= bus.byte_data[BTN_M:BTN_L];
          flags_p1 <= bus.byte_data[YO:XS];
        end
        ST_B1:   b1_p1 <= bus.byte_data;
        ST_B2:   b2_p1 <= bus.byte_data;
        default: b3_p1 <= bus.byte_data[3:0];
      endcase
    end
  end

  assign dx_p1 = sat_delta(flags_p1[XS-XS], flags_p1[XO-XS], b1_p1);
  assign dy_p1 = sat_delta(flags_p1[YS-XS], flags_p1[YO-XS], b2_p1);
  assign sx_p1 = dx_p1 >>> VEL_SHIFT;
  assign sy_p1 = dy_p1 >>> VEL_SHIFT;
  assign nx_p1 = $signed({2'b00, bus.pos_x}) + $signed({{(POS_W-7){sx_p1[8]}}, sx_p1});
  assign ny_p1 = $signed({2'b00, bus.pos_y}) - $signed({{(POS_W-7){sy_p1[8]}}, sy_p1});

  // p1 -> outputs: register decoded packet and update position
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pkt_valid <= 1'b0;
      bus.btn       <= '0;
      bus.delta_x   <= '0;
      bus.delta_y   <= '0;
      bus.wheel     <= '0;
      bus.vx        <= '0;
      bus.vy        <= '0;
      bus.dirx      <= 1'b0;
      bus.diry      <= 1'b0;
      bus.pos_x     <= POS_W'(INIT_X);
      bus.pos_y     <= POS_W'(INIT_Y);
      bus.err_cnt   <= '0;
    end else begin
      bus.pkt_valid <= vld_p1;
      if (vld_p1) begin
        bus.btn     <= btn_p1;
        bus.delta_x <= dx_p1;
        bus.delta_y <= dy_p1;
        bus.wheel   <= (PKT_BYTES == 4) ? $signed(b3_p1) : 4'sd0;
        bus.vx      <= mag9(sx_p1);
        bus.vy      <= mag9(sy_p1);
        bus.dirx    <= ~dx_p1[8];
        bus.diry    <= ~dy_p1[8];
        bus.pos_x   <= clamp_pos(nx_p1, X_MAX_S);
        bus.pos_y   <= clamp_pos(ny_p1, Y_MAX_S);
      end else if (timeout) begin
        bus.vx <= '0;
        bus.vy <= '0;
      end
      if ((drop || abort) && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed bench for the PS/2 mouse packet decoder: three instances cover the
// default build, VEL_SHIFT=0 and 4-byte wheel mode.
module tb_ps2_mouse_packet_decoder;
  logic clk = 1'b0;
  logic rst_a, rst_v, rst_w;
  int   checks = 0;
  int   errors = 0;
  int   cnt_a = 0, cnt_v = 0, cnt_w = 0;
  int   base;
  logic pv_early, pv_hit;

  always #5 clk = ~clk;

  ps2_mouse_packet_decoder_if #(.POS_W(10)) if_a ();
  ps2_mouse_packet_decoder_if #(.POS_W(10)) if_v ();
  ps2_mouse_packet_decoder_if #(.POS_W(10)) if_w ();

  ps2_mouse_packet_decoder #(.PKT_BYTES(3), .TIMEOUT_CYC(100), .VEL_SHIFT(1), .POS_W(10),
    .X_MAX(590), .Y_MAX(430), .INIT_X(320), .INIT_Y(240))
    dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
  ps2_mouse_packet_decoder #(.PKT_BYTES(3), .TIMEOUT_CYC(100), .VEL_SHIFT(0), .POS_W(10),
    .X_MAX(590), .Y_MAX(430), .INIT_X(320), .INIT_Y(240))
    dut_v (.clk(clk), .rst(rst_v), .bus(if_v.slave));
  ps2_mouse_packet_decoder #(.PKT_BYTES(4), .TIMEOUT_CYC(100), .VEL_SHIFT(1), .POS_W(10),
    .X_MAX(590), .Y_MAX(430), .INIT_X(320), .INIT_Y(240))
    dut_w (.clk(clk), .rst(rst_w), .bus(if_w.slave));

  always @(posedge clk) if (if_a.pkt_valid === 1'b1) cnt_a <= cnt_a + 1;
  always @(posedge clk) if (if_v.pkt_valid === 1'b1) cnt_v <= cnt_v + 1;
  always @(posedge clk) if (if_w.pkt_valid === 1'b1) cnt_w <= cnt_w + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic [7:0] b, input logic rdy);
    case (inst)
      0:       begin if_a.byte_data = b; if_a.byte_ready = rdy; end
      1:       begin if_v.byte_data = b; if_v.byte_ready = rdy; end
      default: begin if_w.byte_data = b; if_w.byte_ready = rdy; end
    endcase
  endtask

  function automatic logic pv_of(input int inst);
    case (inst)
      0:       return if_a.pkt_valid;
      1:       return if_v.pkt_valid;
      default: return if_w.pkt_valid;
    endcase
  endfunction

  // Ready rises just before edge k; pkt_valid is due after edge k+3.
  task automatic send(input int inst, input logic [7:0] b);
    @(negedge clk);
    drive(inst, b, 1'b1);
    repeat (3) @(posedge clk);
    #1 pv_early = pv_of(inst);
    @(posedge clk);
    #1 pv_hit = pv_of(inst);
    @(negedge clk);
    drive(inst, b, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send3(input int inst, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    send(inst, b0);
    send(inst, b1);
    send(inst, b2);
  endtask

  initial begin
    rst_a = 1'b1; rst_v = 1'b1; rst_w = 1'b1;
    drive(0, 8'h00, 1'b0); drive(1, 8'h00, 1'b0); drive(2, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_v = 1'b0; rst_w = 1'b0;

    chk("rst_pkt_valid", if_a.pkt_valid, 0);
    chk("rst_pos_x", if_a.pos_x, 320);
    chk("rst_pos_y", if_a.pos_y, 240);
    chk("rst_err", if_a.err_cnt, 0);
    chk("rst_vx", if_a.vx, 0);
    chk("rst_btn", if_a.btn, 0);

    // Test 1
    base = cnt_a;
    send3(0, 8'h08, 8'h10, 8'h08);
    chk("t1_pv_early", pv_early, 0);
    chk("t1_pv_hit", pv_hit, 1);
    chk("t1_pkt_count", cnt_a - base, 1);
    chk("t1_delta_x", if_a.delta_x, 16);
    chk("t1_delta_y", if_a.delta_y, 8);
    chk("t1_vx", if_a.vx, 8);
    chk("t1_vy", if_a.vy, 4);
    chk("t1_dirx", if_a.dirx, 1);
    chk("t1_diry", if_a.diry, 1);
    chk("t1_btn", if_a.btn, 0);
    chk("t1_pos_x", if_a.pos_x, 328);
    chk("t1_pos_y", if_a.pos_y, 236);

    // Test 2
    @(negedge clk) rst_a = 1'b1;
    @(negedge clk) rst_a = 1'b0;
    chk("t2_rst_pos_x", if_a.pos_x, 320);
    send3(0, 8'h39, 8'hF0, 8'hFC);
    chk("t2_pv_hit", pv_hit, 1);
    chk("t2_btn", if_a.btn, 1);
    chk("t2_delta_x", if_a.delta_x, -16);
    chk("t2_delta_y", if_a.delta_y, -4);
    chk("t2_vx", if_a.vx, 8);
    chk("t2_vy", if_a.vy, 2);
    chk("t2_dirx", if_a.dirx, 0);
    chk("t2_diry", if_a.diry, 0);
    chk("t2_pos_x", if_a.pos_x, 312);
    chk("t2_pos_y", if_a.pos_y, 242);

    // Test 3
    @(negedge clk) rst_a = 1'b1;
    @(negedge clk) rst_a = 1'b0;
    base = cnt_a;
    send(0, 8'h01);
    chk("t3_err_drop", if_a.err_cnt, 1);
    chk("t3_no_pkt", cnt_a - base, 0);
    send3(0, 8'h08, 8'h02, 8'h00);
    chk("t3_pv_hit", pv_hit, 1);
    chk("t3_pos_x", if_a.pos_x, 321);
    chk("t3_vx", if_a.vx, 1);

    // Test 4
    base = cnt_a;
    send(0, 8'h08);
    send(0, 8'h10);
    repeat (105) @(negedge clk);
    chk("t4_err_timeout", if_a.err_cnt, 2);
    chk("t4_no_pkt", cnt_a - base, 0);
    chk("t4_vx_zero", if_a.vx, 0);
    chk("t4_delta_x_held", if_a.delta_x, 2);
    chk("t4_pos_x_held", if_a.pos_x, 321);
    send3(0, 8'h08, 8'h00, 8'h00);
    chk("t4_fresh_pv_hit", pv_hit, 1);
    chk("t4_fresh_count", cnt_a - base, 1);
    chk("t4_fresh_delta_x", if_a.delta_x, 0);

    // Test 5
    chk("t5_idle_err", if_v.err_cnt, 0);
    send3(1, 8'h48, 8'h00, 8'h00);
    chk("t5_ovf_delta_x", if_v.delta_x, 255);
    chk("t5_ovf_vx", if_v.vx, 255);
    chk("t5_pos_x_575", if_v.pos_x, 575);
    send3(1, 8'h48, 8'h00, 8'h00);
    chk("t5_pos_x_clamp", if_v.pos_x, 590);
    send3(1, 8'h58, 8'h00, 8'h00);
    chk("t5_neg_ovf_delta_x", if_v.delta_x, -256);
    chk("t5_neg_ovf_vx", if_v.vx, 256);
    chk("t5_neg_ovf_dirx", if_v.dirx, 0);
    chk("t5_pos_x_334", if_v.pos_x, 334);
    send3(1, 8'h28, 8'h00, 8'h80);
    chk("t5_delta_y", if_v.delta_y, -128);
    chk("t5_vy", if_v.vy, 128);
    chk("t5_pos_y_368", if_v.pos_y, 368);
    send3(1, 8'h28, 8'h00, 8'h80);
    chk("t5_pos_y_clamp", if_v.pos_y, 430);
    send3(1, 8'h28, 8'h00, 8'h80);
    chk("t5_pos_y_hold", if_v.pos_y, 430);

    // Test 6
    base = cnt_w;
    send3(2, 8'h08, 8'h00, 8'h00);
    chk("t6_no_pkt_at_b2", cnt_w - base, 0);
    send(2, 8'h0F);
    chk("t6_pv_hit", pv_hit, 1);
    chk("t6_wheel", if_w.wheel, -1);
    send(2, 8'h08);
    send(2, 8'h00);
    @(negedge clk) rst_w = 1'b1;
    @(negedge clk) rst_w = 1'b0;
    chk("t6_rst_wheel", if_w.wheel, 0);
    chk("t6_rst_pkt_valid", if_w.pkt_valid, 0);
    chk("t6_rst_pos_x", if_w.pos_x, 320);
    chk("t6_rst_pos_y", if_w.pos_y, 240);
    base = cnt_w;
    send3(2, 8'h08, 8'h00, 8'h00);
    chk("t6_after_rst_no_pkt", cnt_w - base, 0);
    send(2, 8'h01);
    chk("t6_after_rst_pv_hit", pv_hit, 1);
    chk("t6_after_rst_count", cnt_w - base, 1);
    chk("t6_after_rst_wheel", if_w.wheel, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
